prsim_dualrail_sink: RTL and testbench
======================================

// Module: prsim_dualrail_sink
// PURPOSE
// - Verilog-side receiver for an asynchronous QDI channel driven by prsim via $from_prsim.
// - Decodes a WIDTH-bit dual-rail, four-phase (RTZ) channel and returns the ack rail to prsim via $to_prsim.
// - Buffers received tokens and presents them as a clocked valid/ready stream to the bench.
// - Completes the bench-to-prsim-to-bench loop: prsim circuit outputs become checkable Verilog tokens.
// PARAMETERS
// - WIDTH      8    data bits per token; the channel carries 2*WIDTH rails.
// - DEPTH      4    token FIFO entries; a power of 2, at least 2.
// - TIMEOUT    64   clocks allowed in any single wait for a channel phase change before the stall flag sets.
// PORTS
// - clk           in   1        sampling clock (from clk_gen).
// - rst_n         in   1        asynchronous active-low reset.
// - d_t           in   WIDTH    true rails, from prsim.
// - d_f           in   WIDTH    false rails, from prsim.
// - ack           out  1        channel acknowledge, to prsim.
// - out_valid     out  1        FIFO head valid.
// - out_data      out  WIDTH    FIFO head data; equals d_t as captured.
// - out_ready     in   1        consumer pops the head when out_valid && out_ready.
// - tok_count     out  16       tokens accepted; wraps 0xFFFF -> 0.
// - err_illegal   out  1        sticky: some bit had t=f=1 while synchronised.
// - err_stall     out  1        sticky: TIMEOUT expired in WAIT_VALID_CH or WAIT_NEUTRAL.
// BEHAVIOUR
// - Reset values (async, rst_n=0):
//   - ack=0, out_valid=0, out_data=0, tok_count=0, err_*=0.
//   - FIFO empty; FSM in IDLE; synchronisers cleared to 0.
// - Synchronisation: every rail passes through a 2-flop synchroniser; all decode uses the synchronised rails.
// - Decode, per synchronised cycle:
//   - all_valid = every bit has exactly one rail high.
//   - all_neutral = every rail low.
//   - Otherwise the channel is in transition (partial).
// - FSM states: IDLE, WAIT_VALID_CH, ACK_HI, WAIT_NEUTRAL.
//   - IDLE: enter WAIT_VALID_CH immediately; this state only exists to give the reset/entry point.
//   - WAIT_VALID_CH: when all_valid && FIFO not full, capture d_t into the FIFO, set ack=1, go to ACK_HI.
//     - If FIFO full, stay with ack=0. This is backpressure to prsim.
//   - ACK_HI: unconditional, 1 cycle; increment tok_count; go to WAIT_NEUTRAL.
//   - WAIT_NEUTRAL: when all_neutral, set ack=0 and go to WAIT_VALID_CH.
// - Latency: rails stable valid at edge N -> ack=1 registered at edge N+3 (2 sync + 1 FSM).
//   - The captured token is visible on out_valid at edge N+3 (FIFO write-through not required).
// - Channel rule: a new token is never accepted until neutral has been seen, so each four-phase cycle yields exactly one push.
// - Illegal code: t=f=1 on any synchronised bit, in any state, sets err_illegal.
//   - An illegal code is not all_valid, so it is never captured; the FSM waits.
// - Stall: the wait counter clears on every state change.
//   - Reaching TIMEOUT sets err_stall; the FSM keeps waiting (no recovery, no drop).
//   - The wait counter does not advance in WAIT_VALID_CH while backpressured (FIFO full).
// - FIFO:
//   - Simultaneous push and pop when full is not possible, because push requires not-full.
//   - Simultaneous push and pop when empty is legal: the pushed entry becomes the head next cycle.
//   - Pointers are log2(DEPTH)+1 bits; full/empty come from the MSB compare.
// - Reset mid-handshake: ack drops asynchronously; the FIFO and counts are lost.
//   - After release, the FSM waits for valid. A still-valid channel is re-captured once; the bench accounts for this.
// STRUCTURE
// - Shared include prsim_chan_defs.vh:
//   - FSM state encodings (2-bit localparams).
//   - The TOK_CNT_W=16 width.
//   - Dual-rail decode functions dr_valid() and dr_neutral().
// - Sub-module prsim_sink_fifo: WIDTH x DEPTH synchronous FIFO (push/full, pop/empty, head data).
// - The top level holds the synchronisers, decode, FSM, timeout counter and error flags.
// TESTING
// - Single token: drive d_t=8'hA5, d_f=8'h5A.
//   -> ack=1 three clocks later; out_data=8'hA5; tok_count=1.
//   - Then drive rails to 0 -> ack=0 three clocks later.
// - Backpressure: out_ready=0, push 4 tokens.
//   -> The 5th token gets no ack.
//   - Pop one -> the 5th is acked. Order is preserved: 1,2,3,4,5.
// - Skewed arrival: rails of bit 0..7 rise one clock apart.
//   -> ack rises only after the last bit; exactly 1 push.
// - Illegal code: d_t[3]=d_f[3]=1 for 4 clocks.
//   -> err_illegal=1 and sticky; no push; ack stays 0.
// - Stall: hold the channel valid after ack, never return to neutral.
//   -> err_stall=1 at 64 clocks after WAIT_NEUTRAL entry; ack stays 1.
// - Reset mid-handshake: assert rst_n=0 while ack=1.
//   -> ack=0 immediately; out_valid=0; tok_count=0; after release the valid channel is re-acked once.

Source files
------------

// File: rtl/prsim_dualrail_sink_pkg.sv
// Shared definitions for the prsim dual-rail sink: FSM states, counter width
// and the dual-rail decode helpers.
package prsim_dualrail_sink_pkg;

  // Width of the accepted-token counter.
  localparam int TOK_CNT_W = 16;

  // Widest channel the decode helpers handle; callers zero-extend to this.
  localparam int DR_MAX_W = 64;

  // Receiver handshake states.
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_VALID   = 2'd1,
    ST_ACK_HI       = 2'd2,
    ST_WAIT_NEUTRAL = 2'd3
  } sink_state_e;

  // True when each of the low 'width' bits has exactly one rail high.
  function automatic logic dr_valid(input logic [DR_MAX_W-1:0] t,
                                    input logic [DR_MAX_W-1:0] f,
                                    input int                  width);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DR_MAX_W; i++) begin
      if (i < width) ok = ok & (t[i] ^ f[i]);
    end
    return ok;
  endfunction

  // True when every rail is low (the return-to-zero spacer).
  function automatic logic dr_neutral(input logic [DR_MAX_W-1:0] t,
                                      input logic [DR_MAX_W-1:0] f);
    return ~|(t | f);
  endfunction

  // True when any bit carries the forbidden t=f=1 code.
  function automatic logic dr_illegal(input logic [DR_MAX_W-1:0] t,
                                      input logic [DR_MAX_W-1:0] f);
    return |(t & f);
  endfunction

endpackage

// File: rtl/prsim_dualrail_sink_fifo.sv
// Token FIFO for the dual-rail sink: WIDTH x DEPTH, synchronous push/pop,
// extra pointer MSB distinguishes full from empty.
module prsim_dualrail_sink_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wptr;
  logic [PW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Empty FIFO presents zero so the head output has a defined reset value.
  assign head_data = empty ? '0 : mem[rptr[PW-1:0]];

  // Storage write.
  // NOTE: the array has no reset; stale entries are never visible because
  // the head is masked while empty, and resetting it would only cost flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[PW-1:0]] <= push_data;
  end

  // Pointer advance on accepted push/pop.
  // NOTE: state updates use <= so every flop samples pre-edge values,
  // regardless of the order the simulator evaluates these blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/prsim_dualrail_sink.sv
// Receiver for a four-phase dual-rail QDI channel from prsim: synchronises
// the rails, runs the ack handshake, buffers tokens and flags protocol errors.
module prsim_dualrail_sink
  import prsim_dualrail_sink_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     d_t,
  input  logic [WIDTH-1:0]     d_f,
  output logic                 ack,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ready,
  output logic [TOK_CNT_W-1:0] tok_count,
  output logic                 err_illegal,
  output logic                 err_stall
);

  localparam int                WAIT_W      = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

  logic [WIDTH-1:0]    t_meta, f_meta;
  logic [WIDTH-1:0]    t_sync, f_sync;
  logic [DR_MAX_W-1:0] t_ext, f_ext;
  logic                all_valid, all_neutral, any_illegal;

  sink_state_e         state, state_next;
  logic                ack_next;
  logic                push;
  logic                tok_inc;
  logic                waiting;
  logic                wait_hold;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_next;

  logic                fifo_full, fifo_empty;

  // Two-flop synchroniser on every rail; prsim drives them asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_meta <= '0;
      f_meta <= '0;
      t_sync <= '0;
      f_sync <= '0;
    end else begin
      t_meta <= d_t;
      f_meta <= d_f;
      t_sync <= t_meta;
      f_sync <= f_meta;
    end
  end

  // Dual-rail decode of the synchronised rails.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    t_ext              = '0;
    f_ext              = '0;
    t_ext[WIDTH-1:0]   = t_sync;
    f_ext[WIDTH-1:0]   = f_sync;
    all_valid          = dr_valid(t_ext, f_ext, WIDTH);
    all_neutral        = dr_neutral(t_ext, f_ext);
    any_illegal        = dr_illegal(t_ext, f_ext);
  end

  // Handshake next-state and control strobes.
  always_comb begin
    state_next = state;
    ack_next   = ack;
    push       = 1'b0;
    tok_inc    = 1'b0;
    waiting    = 1'b0;
    wait_hold  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        state_next = ST_WAIT_VALID;
      end
      ST_WAIT_VALID: begin
        waiting = 1'b1;
        if (fifo_full) begin
          // Withholding ack is the backpressure seen by prsim.
          wait_hold = 1'b1;
        end else if (all_valid) begin
          push       = 1'b1;
          ack_next   = 1'b1;
          state_next = ST_ACK_HI;
        end
      end
      ST_ACK_HI: begin
        tok_inc    = 1'b1;
        state_next = ST_WAIT_NEUTRAL;
      end
      ST_WAIT_NEUTRAL: begin
        waiting = 1'b1;
        if (all_neutral) begin
          ack_next   = 1'b0;
          state_next = ST_WAIT_VALID;
        end
      end
      default: begin
        ack_next   = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // Phase-wait counter: cleared on any state change, frozen under backpressure,
  // saturating at TIMEOUT.
  always_comb begin
    wait_cnt_next = wait_cnt;
    if (state_next != state) begin
      wait_cnt_next = '0;
    end else if (waiting && !wait_hold && (wait_cnt != TIMEOUT_CNT)) begin
      wait_cnt_next = wait_cnt + 1'b1;
    end
  end

  // State, ack, counters and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ack         <= 1'b0;
      wait_cnt    <= '0;
      tok_count   <= '0;
      err_illegal <= 1'b0;
      err_stall   <= 1'b0;
    end else begin
      state    <= state_next;
      ack      <= ack_next;
      wait_cnt <= wait_cnt_next;
      if (tok_inc)                       tok_count   <= tok_count + 1'b1;
      if (any_illegal)                   err_illegal <= 1'b1;
      if (wait_cnt_next == TIMEOUT_CNT)  err_stall   <= 1'b1;
    end
  end

  // Token buffer; the captured value is the true-rail word.
  prsim_dualrail_sink_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (t_sync),
    .pop       (out_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (out_data)
  );

  assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_prsim_dualrail_sink.sv
// Bench for prsim_dualrail_sink: plays the prsim side of the four-phase
// channel, keeps an expected-token queue and a token count, and a monitor
// compares every token the sink hands out.
module tb_prsim_dualrail_sink;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] d_t = '0;
  logic [WIDTH-1:0] d_f = '0;
  logic             out_ready = 1'b0;
  logic             ack;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [15:0]      tok_count;
  logic             err_illegal;
  logic             err_stall;

  int               compared   = 0;
  int               mismatched = 0;
  logic [WIDTH-1:0] exp_q [$];
  int               exp_tok = 0;
  logic             random_ready = 1'b0;

  prsim_dualrail_sink #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .d_t         (d_t),
    .d_f         (d_f),
    .ack         (ack),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .tok_count   (tok_count),
    .err_illegal (err_illegal),
    .err_stall   (err_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance n clocks, leaving time just past the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_valid(input logic [WIDTH-1:0] v);
    d_t = v;
    d_f = ~v;
    exp_q.push_back(v);
  endtask

  task automatic drive_neutral();
    d_t = '0;
    d_f = '0;
  endtask

  task automatic wait_ack(input logic level, input int budget, input string name);
    int n;
    n = 0;
    while (ack !== level && n < budget) begin
      tick(1);
      n++;
    end
    check(name, 32'(ack), 32'(level));
  endtask

  task automatic handshake(input logic [WIDTH-1:0] v);
    drive_valid(v);
    wait_ack(1'b1, 200, "hs_ack_rise");
    exp_tok++;
    drive_neutral();
    wait_ack(1'b0, 50, "hs_ack_fall");
  endtask

  // Scoreboard monitor: a pop happens at the next rising edge whenever the
  // head is valid and ready is high; compare it against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL token_unexpected: got 0x%0h, expected no token", out_data);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        check("token_data", 32'(out_data), 32'(e));
      end
    end
  end

  // Random consumer readiness during the randomized phase.
  always begin
    @(posedge clk);
    #1;
    if (random_ready) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] v;
    logic             ack_seen;

    // Reset state.
    tick(3);
    check("rst_ack",         32'(ack),         0);
    check("rst_out_valid",   32'(out_valid),   0);
    check("rst_out_data",    32'(out_data),    0);
    check("rst_tok_count",   32'(tok_count),   0);
    check("rst_err_illegal", 32'(err_illegal), 0);
    check("rst_err_stall",   32'(err_stall),   0);
    rst_n = 1'b1;
    tick(2);

    // Single token: three-clock ack latency each way.
    drive_valid(8'hA5);
    tick(2);
    check("single_ack_early", 32'(ack), 0);
    tick(1);
    check("single_ack_rise", 32'(ack),       1);
    check("single_valid",    32'(out_valid), 1);
    check("single_data",     32'(out_data),  32'h0A5);
    tick(1);
    exp_tok++;
    check("single_tok_count", 32'(tok_count), 32'(exp_tok));
    drive_neutral();
    tick(2);
    check("single_ack_hold", 32'(ack), 1);
    tick(1);
    check("single_ack_fall", 32'(ack), 0);
    out_ready = 1'b1;
    tick(2);
    check("single_drained", 32'(out_valid), 0);
    out_ready = 1'b0;

    // Backpressure: fill the FIFO, the fifth token must wait for a pop.
    for (int k = 1; k <= DEPTH; k++) handshake(8'(8'h11 * k));
    drive_valid(8'h55);
    tick(20);
    check("bp_fifth_no_ack", 32'(ack),       0);
    check("bp_full_valid",   32'(out_valid), 1);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    wait_ack(1'b1, 20, "bp_fifth_ack");
    exp_tok++;
    drive_neutral();
    wait_ack(1'b0, 20, "bp_fifth_ack_fall");
    out_ready = 1'b1;
    tick(7);
    check("bp_drained",   32'(out_valid), 0);
    check("bp_tok_count", 32'(tok_count), 32'(exp_tok));

    // Skewed arrival: one bit completes per clock; ack only after the last.
    v = 8'($urandom);
    exp_q.push_back(v);
    ack_seen = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      d_t[i] = v[i];
      d_f[i] = ~v[i];
      tick(1);
      ack_seen = ack_seen | ack;
    end
    tick(1);
    ack_seen = ack_seen | ack;
    check("skew_ack_early", 32'(ack_seen), 0);
    tick(1);
    check("skew_ack_rise", 32'(ack), 1);
    exp_tok++;
    drive_neutral();
    wait_ack(1'b0, 20, "skew_ack_fall");
    tick(3);
    check("skew_tok_count", 32'(tok_count), 32'(exp_tok));
    check("skew_one_push",  32'(exp_q.size()), 0);

    // Illegal code on bit 3 for four clocks.
    check("ill_pre", 32'(err_illegal), 0);
    ack_seen = 1'b0;
    d_t = 8'h08;
    d_f = 8'h08;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      ack_seen = ack_seen | ack;
    end
    drive_neutral();
    for (int i = 0; i < 3; i++) begin
      tick(1);
      ack_seen = ack_seen | ack;
    end
    check("ill_flag", 32'(err_illegal), 1);
    tick(5);
    check("ill_sticky",    32'(err_illegal), 1);
    check("ill_no_ack",    32'(ack_seen),    0);
    check("ill_no_push",   32'(tok_count),   32'(exp_tok));
    check("ill_no_valid",  32'(out_valid),   0);

    // Randomized tokens with a randomly ready consumer.
    random_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      tick($urandom_range(0, 3));
      handshake(8'($urandom));
    end
    random_ready = 1'b0;
    out_ready = 1'b1;
    tick(8);
    check("rand_drained",   32'(out_valid),    0);
    check("rand_queue",     32'(exp_q.size()), 0);
    check("rand_tok_count", 32'(tok_count),    32'(exp_tok));

    // Stall: channel held valid after ack, never returns to neutral.
    check("stall_pre", 32'(err_stall), 0);
    out_ready = 1'b0;
    v = 8'($urandom);
    drive_valid(v);
    wait_ack(1'b1, 20, "stall_ack");
    exp_tok++;
    tick(TIMEOUT);
    check("stall_early", 32'(err_stall), 0);
    tick(1);
    check("stall_flag",     32'(err_stall), 1);
    check("stall_ack_held", 32'(ack),       1);
    check("stall_tok",      32'(tok_count), 32'(exp_tok));

    // Reset mid-handshake, then the still-valid channel is captured once more.
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack",       32'(ack),       0);
    check("mid_rst_valid",     32'(out_valid), 0);
    check("mid_rst_tok",       32'(tok_count), 0);
    check("mid_rst_err_stall", 32'(err_stall), 0);
    exp_q.delete();
    exp_tok = 0;
    tick(2);
    rst_n = 1'b1;
    exp_q.push_back(v);
    wait_ack(1'b1, 20, "mid_rst_reack");
    exp_tok++;
    drive_neutral();
    wait_ack(1'b0, 20, "mid_rst_ack_fall");
    out_ready = 1'b1;
    tick(4);
    check("mid_rst_tok_after", 32'(tok_count),    32'(exp_tok));
    check("mid_rst_queue",     32'(exp_q.size()), 0);
    check("mid_rst_drained",   32'(out_valid),    0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
